// File: rtl/addr_tree_acc_if.sv
// Operand beat in, tree/accumulator result out; the master drives beats and the slave is the adder.
interface addr_tree_acc_if #(
    parameter int IN_WIDTH = 32,
    parameter int NUM_IN   = 8,
    parameter int ACC_BITS = 4
);
    localparam int LVL   = $clog2(NUM_IN);
    localparam int OUT_W = IN_WIDTH + LVL + ACC_BITS;

    logic [NUM_IN*IN_WIDTH-1:0] d_i;
    logic                       vld_i;
    logic                       first_i;
    logic                       last_i;
    logic                       acc_en_i;
    logic [OUT_W-1:0]           d_o;
    logic                       vld_o;
    logic                       ovf_o;

    modport master (
        output d_i, vld_i, first_i, last_i, acc_en_i,
        input  d_o, vld_o, ovf_o
    );

    modport slave (
        input  d_i, vld_i, first_i, last_i, acc_en_i,
        output d_o, vld_o, ovf_o
    );
endinterface

// File: rtl/addr_tree_acc.sv
// Pipelined signed adder tree with optional group accumulation; LVL+1 cycle latency.
// One beat per cycle, never stalls; bubbles (vld_i=0) leave all state untouched.
module addr_tree_acc #(
    parameter int IN_WIDTH = 32,
    parameter int NUM_IN   = 8,
    parameter int ACC_BITS = 4
) (
    input  logic           clk,
    input  logic           rst,
    addr_tree_acc_if.slave bus
);
    localparam int LVL   = $clog2(NUM_IN);
    localparam int SUM_W = IN_WIDTH + LVL;
    localparam int OUT_W = SUM_W + ACC_BITS;
    localparam int TOP   = LVL - 1;

    typedef struct packed {
        logic acc_en;
        logic last;
        logic first;
        logic vld;
    } ctl_t;

    logic signed [SUM_W-1:0] op [NUM_IN];
    ctl_t                    ctl_in;

    always_comb begin
        for (int k = 0; k < NUM_IN; k++) begin
            op[k] = SUM_W'($signed(bus.d_i[k*IN_WIDTH +: IN_WIDTH]));
        end
    end

    assign ctl_in = {bus.acc_en_i, bus.last_i, bus.first_i, bus.vld_i};

    // Every level keeps NUM_IN lanes at full SUM_W; lanes past the live count stay zero,
    // which gives the zero-padding of an odd operand for free.
    for (genvar lv = 0; lv < LVL; lv++) begin : g_lvl
        logic signed [SUM_W-1:0] src   [NUM_IN];
        logic signed [SUM_W-1:0] sum_d [NUM_IN];
        logic signed [SUM_W-1:0] sum_q [NUM_IN];
        ctl_t                    ctl_src;
        ctl_t                    ctl_q;

        if (lv == 0) begin : g_head
            assign src     = op;
            assign ctl_src = ctl_in;
        end else begin : g_body
            assign src     = g_lvl[lv-1].sum_q;
            assign ctl_src = g_lvl[lv-1].ctl_q;
        end

        always_comb begin
            for (int k = 0; k < NUM_IN; k++) begin
                sum_d[k] = '0;
            end
            for (int k = 0; k < NUM_IN / 2; k++) begin
                sum_d[k] = src[2*k] + src[2*k+1];
            end
            if (NUM_IN % 2 == 1) begin
                sum_d[NUM_IN/2] = src[NUM_IN-1];
            end
        end

        always_ff @(posedge clk) begin
            if (ctl_src.vld) begin
                sum_q <= sum_d;
            end
            if (rst) begin
                ctl_q <= '0;
            end else begin
                ctl_q <= ctl_src;
            end
        end
    end

    ctl_t                    ctl;
    logic signed [OUT_W-1:0] sum_ext;
    logic signed [OUT_W-1:0] add_base;
    logic signed [OUT_W-1:0] acc_sum;
    logic                    add_ovf;
    logic signed [OUT_W-1:0] acc_q,   acc_d;
    logic                    ovf_q,   ovf_d;
    logic signed [OUT_W-1:0] d_o_q,   d_o_d;
    logic                    ovf_o_q, ovf_o_d;
    logic                    vld_o_q, vld_o_d;

    assign ctl     = g_lvl[TOP].ctl_q;
    assign sum_ext = OUT_W'(g_lvl[TOP].sum_q[0]);

    // A first beat restarts from zero, so it can never overflow and clears the sticky flag.
    always_comb begin
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        d_o_d    = d_o_q;
        ovf_o_d  = ovf_o_q;
        vld_o_d  = 1'b0;
        add_base = ctl.first ? '0 : acc_q;
        acc_sum  = add_base + sum_ext;
        add_ovf  = (add_base[OUT_W-1] == sum_ext[OUT_W-1]) &&
                   (acc_sum[OUT_W-1] != sum_ext[OUT_W-1]);
        if (ctl.vld) begin
            if (!ctl.acc_en) begin
                d_o_d   = sum_ext;
                ovf_o_d = 1'b0;
                vld_o_d = 1'b1;
            end else begin
                acc_d = acc_sum;
                ovf_d = (ovf_q && !ctl.first) || add_ovf;
                if (ctl.last) begin
                    d_o_d   = acc_sum;
                    ovf_o_d = ovf_d;
                    vld_o_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            d_o_q   <= '0;
            ovf_o_q <= 1'b0;
            vld_o_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            d_o_q   <= d_o_d;
            ovf_o_q <= ovf_o_d;
            vld_o_q <= vld_o_d;
        end
    end

    assign bus.d_o   = d_o_q;
    assign bus.vld_o = vld_o_q;
    assign bus.ovf_o = ovf_o_q;
endmodule
